// File: rtl/fa_call_array.sv
// Multi-seat flight-attendant call controller.
// Each seat runs an independent IDLE/CALLING/ESCALATED FSM with its own
// escalation timer; the top level ranks the seats for the attendant panel
// and routes a single acknowledge to whichever seat is shown on next_seat.

module fa_call_seat #(
    parameter int ESC_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic call,
    input  logic clr,
    output logic lit,
    output logic esc
);
    localparam int TW = $clog2(ESC_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(ESC_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALLING, S_ESC} seat_state_e;

    seat_state_e       state;
    logic [TW-1:0]     timer;

    // Seat FSM: a clear always wins over a call arriving in the same cycle,
    // and the timer only runs while CALLING (frozen once escalated).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (call && !clr) begin
                        state <= S_CALLING;
                        timer <= '0;
                    end
                end
                S_CALLING: begin
                    if (clr)
                        state <= S_IDLE;
                    else if (timer == T_LAST)
                        state <= S_ESC;
                    else
                        timer <= timer + 1'b1;
                end
                S_ESC: begin
                    if (clr)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Light and escalation flags decoded straight from the state register.
    assign lit = (state != S_IDLE);
    assign esc = (state == S_ESC);
endmodule

module fa_call_array #(
    parameter int N_SEATS    = 8,
    parameter int ESC_CYCLES = 16,
    parameter int IDX_W      = (N_SEATS > 1) ? $clog2(N_SEATS) : 1,
    parameter int CNT_W      = $clog2(N_SEATS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SEATS-1:0] call_button,
    input  logic [N_SEATS-1:0] cancel_button,
    input  logic               ack,
    output logic [N_SEATS-1:0] light_state,
    output logic [N_SEATS-1:0] escalate,
    output logic               any_call,
    output logic [IDX_W-1:0]   next_seat,
    output logic               next_valid,
    output logic [CNT_W-1:0]   pending_count
);
    logic [N_SEATS-1:0] clr;
    logic               found_esc;
    logic               found_call;
    logic [IDX_W-1:0]   esc_idx;
    logic [IDX_W-1:0]   call_idx;

    // One FSM per seat; ack only reaches the seat currently offered to the panel.
    for (genvar g = 0; g < N_SEATS; g++) begin : g_seat
        assign clr[g] = cancel_button[g] |
                        (ack & next_valid & (next_seat == IDX_W'(g)));

        fa_call_seat #(
            .ESC_CYCLES (ESC_CYCLES)
        ) u_seat (
            .clk   (clk),
            .reset (reset),
            .call  (call_button[g]),
            .clr   (clr[g]),
            .lit   (light_state[g]),
            .esc   (escalate[g])
        );
    end

    // Next-seat ranking: lowest escalated seat first, then lowest calling seat.
    // Driven from seat state only so button bounce never reaches the panel.
    always_comb begin
        found_esc  = 1'b0;
        found_call = 1'b0;
        esc_idx    = '0;
        call_idx   = '0;
        for (int i = 0; i < N_SEATS; i++) begin
            if (escalate[i] && !found_esc) begin
                found_esc = 1'b1;
                esc_idx   = IDX_W'(i);
            end
            if (light_state[i] && !found_call) begin
                found_call = 1'b1;
                call_idx   = IDX_W'(i);
            end
        end
        next_seat = found_esc ? esc_idx : call_idx;
    end

    // Number of lit seats for the attendant display.
    always_comb begin
        pending_count = '0;
        for (int i = 0; i < N_SEATS; i++)
            pending_count = pending_count + CNT_W'(light_state[i]);
    end

    assign any_call   = |light_state;
    assign next_valid = any_call;
endmodule

// File: tb/tb_fa_call_array.sv
// Directed bench for fa_call_array (4 seats, escalation after 8 cycles).
// Expected panel states are queued when a step is driven and popped once
// the DUT has had its clock edge.

module tb_fa_call_array;
    localparam int N  = 4;
    localparam int EC = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] call_button;
    logic [N-1:0] cancel_button;
    logic         ack;
    logic [N-1:0] light_state;
    logic [N-1:0] escalate;
    logic         any_call;
    logic [1:0]   next_seat;
    logic         next_valid;
    logic [2:0]   pending_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [3:0] light;
        logic [3:0] esc;
        logic [1:0] nxt;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    fa_call_array #(
        .N_SEATS    (N),
        .ESC_CYCLES (EC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_button   (call_button),
        .cancel_button (cancel_button),
        .ack           (ack),
        .light_state   (light_state),
        .escalate      (escalate),
        .any_call      (any_call),
        .next_seat     (next_seat),
        .next_valid    (next_valid),
        .pending_count (pending_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] l, input logic [3:0] e,
                        input logic [1:0] n, input logic [2:0] c);
        exp_t x;
        x.tag = tag; x.light = l; x.esc = e; x.nxt = n; x.cnt = c;
        exp_q.push_back(x);
    endtask

    task automatic check();
        exp_t x;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        x = exp_q.pop_front();
        cmp({x.tag, ".light"}, 32'(light_state), 32'(x.light));
        cmp({x.tag, ".esc"},   32'(escalate),    32'(x.esc));
        cmp({x.tag, ".next"},  32'(next_seat),   32'(x.nxt));
        cmp({x.tag, ".cnt"},   32'(pending_count), 32'(x.cnt));
        cmp({x.tag, ".valid"}, 32'(next_valid),  32'(|x.light));
        cmp({x.tag, ".any"},   32'(any_call),    32'(|x.light));
    endtask

    task automatic expect_now(input string tag, input logic [3:0] l, input logic [3:0] e,
                              input logic [1:0] n, input logic [2:0] c);
        push(tag, l, e, n, c);
        check();
    endtask

    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; call_button = '0; cancel_button = '0; ack = 1'b0;
        #3;
        expect_now("reset_init", 4'b0000, 4'b0000, 2'd0, 3'd0);
        #9 reset = 1'b1;        // t=12, between edges
        cycle();

        // Seat 2 call, escalates exactly EC edges after the light rises.
        call_button = 4'b0100;
        cycle();
        call_button = 4'b0000;
        expect_now("s2_call", 4'b0100, 4'b0000, 2'd2, 3'd1);
        cycle(EC - 1);
        expect_now("s2_pre_esc", 4'b0100, 4'b0000, 2'd2, 3'd1);
        cycle();
        expect_now("s2_esc", 4'b0100, 4'b0100, 2'd2, 3'd1);
        cancel_button = 4'b0100;
        cycle();
        cancel_button = 4'b0000;
        expect_now("s2_cancel", 4'b0000, 4'b0000, 2'd0, 3'd0);

        // Call and cancel together: cancel wins.
        call_button = 4'b0010; cancel_button = 4'b0010;
        cycle();
        call_button = 4'b0000; cancel_button = 4'b0000;
        expect_now("s1_call_cancel_same", 4'b0000, 4'b0000, 2'd0, 3'd0);

        // Call seat 1, cancel 3 cycles later; no escalation afterwards.
        call_button = 4'b0010;
        cycle();
        call_button = 4'b0000;
        expect_now("s1_call", 4'b0010, 4'b0000, 2'd1, 3'd1);
        cycle(2);
        cancel_button = 4'b0010;
        cycle();
        cancel_button = 4'b0000;
        expect_now("s1_cancel", 4'b0000, 4'b0000, 2'd0, 3'd0);
        cycle(EC);
        expect_now("s1_no_esc", 4'b0000, 4'b0000, 2'd0, 3'd0);

        // Escalated seat 3 outranks newer call on seat 0; ack twice, third ignored.
        call_button = 4'b1000;
        cycle();
        call_button = 4'b0000;
        cycle(EC - 1);
        call_button = 4'b0001;
        cycle();
        call_button = 4'b0000;
        expect_now("prio_esc_first", 4'b1001, 4'b1000, 2'd3, 3'd2);
        ack = 1'b1;
        cycle();
        expect_now("ack_s3", 4'b0001, 4'b0000, 2'd0, 3'd1);
        cycle();
        expect_now("ack_s0", 4'b0000, 4'b0000, 2'd0, 3'd0);
        cycle();
        ack = 1'b0;
        expect_now("ack_ignored", 4'b0000, 4'b0000, 2'd0, 3'd0);

        // Three simultaneous calls; ack seat 0 while its button stays held.
        call_button = 4'b0111;
        cycle();
        expect_now("three_calls", 4'b0111, 4'b0000, 2'd0, 3'd3);
        call_button = 4'b0001; ack = 1'b1;
        cycle();
        ack = 1'b0;
        expect_now("ack_held_idle", 4'b0110, 4'b0000, 2'd1, 3'd2);
        cycle();
        call_button = 4'b0000;
        expect_now("held_recall", 4'b0111, 4'b0000, 2'd0, 3'd3);
        cycle(EC - 2);
        expect_now("s12_esc", 4'b0111, 4'b0110, 2'd1, 3'd3);
        cycle();
        expect_now("s0_timer_restarted", 4'b0111, 4'b0110, 2'd1, 3'd3);
        cycle();
        expect_now("s0_esc", 4'b0111, 4'b0111, 2'd0, 3'd3);
        cancel_button = 4'b1111;
        cycle();
        cancel_button = 4'b0000;
        expect_now("cancel_all", 4'b0000, 4'b0000, 2'd0, 3'd0);

        // Cancel on the very edge where the timer reaches its last value.
        call_button = 4'b0100;
        cycle();
        call_button = 4'b0000;
        cycle(EC - 1);
        cancel_button = 4'b0100;
        cycle();
        cancel_button = 4'b0000;
        expect_now("cancel_at_last", 4'b0000, 4'b0000, 2'd0, 3'd0);
        cycle(3);
        expect_now("cancel_at_last_hold", 4'b0000, 4'b0000, 2'd0, 3'd0);

        // Reset mid-operation with seat 3 escalated and seat 1 calling.
        call_button = 4'b1000;
        cycle();
        call_button = 4'b0000;
        cycle(EC - 1);
        call_button = 4'b0010;
        cycle();
        call_button = 4'b0000;
        expect_now("pre_reset", 4'b1010, 4'b1000, 2'd3, 3'd2);
        #2 reset = 1'b0;
        #1;
        expect_now("async_reset", 4'b0000, 4'b0000, 2'd0, 3'd0);
        #2 reset = 1'b1;
        cycle();
        expect_now("post_reset", 4'b0000, 4'b0000, 2'd0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
